sr_driver: RTL and testbench

Synchronous driver for the asynchronous `sr` latch: converts one noisy level input (pushbutton or SPDT switch on the MAX1000) into clean, mutually exclusive set/reset pulses. The input is synchronized and debounced, then each accepted rising level emits an `s` pulse and each accepted falling level emits an `r` pulse. It sits between board I/O and any `sr` latch instance, and guarantees `s` and `r` are never asserted together.

---
 rtl/sr_driver_pkg.sv | 20 ++
 rtl/sync2.sv | 24 ++
 rtl/sr_driver.sv | 99 +++++++++
 tb/tb_sr_driver.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sr_driver_pkg.sv
// Shared types and helpers for the sr_driver debouncer / pulse generator.
package sr_driver_pkg;

    typedef enum logic [2:0] {
        STABLE_LO = 3'd0,
        DEB_HI    = 3'd1,
        PULSE_SET = 3'd2,
        STABLE_HI = 3'd3,
        DEB_LO    = 3'd4,
        PULSE_RST = 3'd5
    } state_e;

    // One counter serves both phases, so size it for the longer of the two.
    function automatic int cnt_width(input int deb_cycles, input int pulse_cycles);
        int m;
        m = (deb_cycles > pulse_cycles) ? deb_cycles : pulse_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sr_driver.sv
// Debounces one raw level and turns each accepted edge into an exclusive
// set (rising) or reset (falling) pulse for a downstream sr latch.
module sr_driver
    import sr_driver_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s,
    output logic r,
    output logic level,
    output logic busy
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, PULSE_CYCLES);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

    logic          din_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_q, s_d, r_q, r_d, level_q, level_d, busy_q, busy_d;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (din),
        .q_o (din_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STABLE_LO: if (din_s) state_d = DEB_HI;
            DEB_HI: begin
                if (!din_s)                 state_d = STABLE_LO;
                else if (cnt_q == DEB_LAST) state_d = PULSE_SET;
            end
            PULSE_SET: if (cnt_q == PULSE_LAST) state_d = STABLE_HI;
            STABLE_HI: if (!din_s) state_d = DEB_LO;
            DEB_LO: begin
                if (din_s)                  state_d = STABLE_HI;
                else if (cnt_q == DEB_LAST) state_d = PULSE_RST;
            end
            PULSE_RST: if (cnt_q == PULSE_LAST) state_d = STABLE_LO;
            default: state_d = STABLE_LO;
        endcase
        // Counter restarts on every state entry and only runs in timed states.
        if (state_d != state_q || state_q == STABLE_LO || state_q == STABLE_HI)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    // Outputs are decoded from the next state and registered, so the pins
    // change exactly at the state-entry edge and never glitch.
    always_comb begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        level_d = 1'b0;
        busy_d  = 1'b0;
        unique case (state_d)
            STABLE_LO: ;
            DEB_HI:    busy_d = 1'b1;
            PULSE_SET: begin s_d = 1'b1; level_d = 1'b1; busy_d = 1'b1; end
            STABLE_HI: level_d = 1'b1;
            DEB_LO:    begin level_d = 1'b1; busy_d = 1'b1; end
            PULSE_RST: begin r_d = 1'b1; busy_d = 1'b1; end
            default: ;
        endcase
    end

    assign s     = s_q;
    assign r     = r_q;
    assign level = level_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sr_driver.sv
// Directed bench for sr_driver with DEBOUNCE_CYCLES=4, PULSE_CYCLES=2.
module tb_sr_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic s, r, level, busy;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    typedef struct {
        logic rst;
        logic din;
        logic s;
        logic r;
        logic level;
        logic busy;
    } vec_t;

    vec_t vecs[$];

    sr_driver #(
        .DEBOUNCE_CYCLES (4),
        .PULSE_CYCLES    (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .s     (s),
        .r     (r),
        .level (level),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic void add(input int n, input logic rv, input logic dv,
                                input logic es, input logic er,
                                input logic el, input logic eb);
        vec_t v;
        v.rst = rv; v.din = dv; v.s = es; v.r = er; v.level = el; v.busy = eb;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic chk(input string tag, input string sig, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d %s: got %b expected %b", tag, edge_no, sig, act, exp);
        end
    endtask

    // Drive inputs, clock once, then compare all outputs 1 time unit later.
    task automatic cyc(input string tag, input logic rv, input logic dv,
                       input logic es, input logic er, input logic el, input logic eb);
        rst = rv;
        din = dv;
        @(posedge clk);
        #1;
        chk(tag, "s", s, es);
        chk(tag, "r", r, er);
        chk(tag, "level", level, el);
        chk(tag, "busy", busy, eb);
        chk(tag, "s&r", s & r, 1'b0);
        $display("%s edge %0d rst=%b din=%b -> s=%b r=%b level=%b busy=%b",
                 tag, edge_no, rv, dv, s, r, level, busy);
        edge_no++;
    endtask

    initial begin
        // Reset, rising edge with din high before edge 10, falling edge, glitch.
        add(3, 1, 0, 0, 0, 0, 0);   // 0-2   reset
        add(7, 0, 0, 0, 0, 0, 0);   // 3-9   idle low
        add(2, 0, 1, 0, 0, 0, 0);   // 10-11 synchronizer latency
        add(4, 0, 1, 0, 0, 0, 1);   // 12-15 DEB_HI
        add(2, 0, 1, 1, 0, 1, 1);   // 16-17 PULSE_SET
        add(4, 0, 1, 0, 0, 1, 0);   // 18-21 STABLE_HI
        add(2, 0, 0, 0, 0, 1, 0);   // 22-23 synchronizer latency
        add(4, 0, 0, 0, 0, 1, 1);   // 24-27 DEB_LO
        add(2, 0, 0, 0, 1, 0, 1);   // 28-29 PULSE_RST
        add(4, 0, 0, 0, 0, 0, 0);   // 30-33 STABLE_LO
        add(2, 0, 1, 0, 0, 0, 0);   // 34-35 glitch starts
        add(1, 0, 1, 0, 0, 0, 1);   // 36    DEB_HI
        add(2, 0, 0, 0, 0, 0, 1);   // 37-38 still debouncing
        add(4, 0, 0, 0, 0, 0, 0);   // 39-42 rejected, back to STABLE_LO

        foreach (vecs[i])
            cyc("table", vecs[i].rst, vecs[i].din, vecs[i].s, vecs[i].r,
                vecs[i].level, vecs[i].busy);

        // din toggles inside PULSE_SET: pulse completes, then low is re-debounced.
        edge_no = 0;
        cyc("toggle", 0, 1, 0, 0, 0, 0);
        cyc("toggle", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("toggle", 0, 1, 0, 0, 0, 1);
        cyc("toggle", 0, 0, 0, 0, 0, 1);
        cyc("toggle", 0, 1, 1, 0, 1, 1);
        cyc("toggle", 0, 0, 1, 0, 1, 1);
        cyc("toggle", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc("toggle", 0, 0, 0, 0, 1, 1);
        cyc("toggle", 0, 0, 0, 1, 0, 1);
        cyc("toggle", 0, 0, 0, 1, 0, 1);
        cyc("toggle", 0, 0, 0, 0, 0, 0);

        // Reset mid-PULSE_SET with din held high: pulse truncated, fresh pulse later.
        edge_no = 0;
        cyc("rstmid", 0, 1, 0, 0, 0, 0);
        cyc("rstmid", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("rstmid", 0, 1, 0, 0, 0, 1);
        cyc("rstmid", 0, 1, 1, 0, 1, 1);
        cyc("rstmid", 1, 1, 0, 0, 0, 0);
        cyc("rstmid", 0, 1, 0, 0, 0, 0);
        cyc("rstmid", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("rstmid", 0, 1, 0, 0, 0, 1);
        cyc("rstmid", 0, 1, 1, 0, 1, 1);
        cyc("rstmid", 0, 1, 1, 0, 1, 1);
        cyc("rstmid", 0, 1, 0, 0, 1, 0);
        cyc("rstmid", 0, 1, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
